// File: rtl/crypto_sha512_pipe.sv
// SHA-512 sigma/sum datapath (Zknh, RV64 and RV32 forms) behind an elastic valid/ready pipeline.
// The result is computed before stage 0; the stages only carry {valid, result, tag, illegal}.
package crypto_instr_pkg;
    typedef enum logic [3:0] {
        SHA512_SUM0  = 4'd0,
        SHA512_SUM1  = 4'd1,
        SHA512_SIG0  = 4'd2,
        SHA512_SIG1  = 4'd3,
        SHA512_SUM0R = 4'd4,
        SHA512_SUM1R = 4'd5,
        SHA512_SIG0H = 4'd6,
        SHA512_SIG0L = 4'd7,
        SHA512_SIG1H = 4'd8,
        SHA512_SIG1L = 4'd9
    } sha512_t;
endpackage

module crypto_sha512_pipe
    import crypto_instr_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned PIPE_STAGES = 1,
    parameter int unsigned TRANS_ID_W  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  sha512_t               op_i,
    input  logic [XLEN-1:0]       rs1_i,
    input  logic [XLEN-1:0]       rs2_i,
    input  logic [TRANS_ID_W-1:0] trans_id_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [XLEN-1:0]       result_o,
    output logic [TRANS_ID_W-1:0] trans_id_o,
    output logic                  illegal_o
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $fatal(1, "crypto_sha512_pipe: XLEN must be 32 or 64");
    end
    if (PIPE_STAGES > 3) begin : g_bad_stages
        $fatal(1, "crypto_sha512_pipe: PIPE_STAGES must be 0..3");
    end

    typedef struct packed {
        logic [XLEN-1:0]       result;
        logic [TRANS_ID_W-1:0] trans_id;
        logic                  illegal;
    } payload_t;

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    logic [63:0]     a64, b64;
    logic [31:0]     a32, b32;
    logic            unused_b_hi;
    logic [XLEN-1:0] comp_result;
    logic            comp_illegal;

    assign a64         = 64'(rs1_i);
    assign b64         = 64'(rs2_i);
    assign a32         = a64[31:0];
    assign b32         = b64[31:0];
    assign unused_b_hi = ^b64[63:32];

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        comp_result  = '0;
        comp_illegal = 1'b1;
        if (XLEN == 64) begin
            case (op_i)
                SHA512_SIG0: begin
                    comp_result  = XLEN'(ror64(a64, 1) ^ ror64(a64, 8) ^ (a64 >> 7));
                    comp_illegal = 1'b0;
                end
                SHA512_SIG1: begin
                    comp_result  = XLEN'(ror64(a64, 19) ^ ror64(a64, 61) ^ (a64 >> 6));
                    comp_illegal = 1'b0;
                end
                SHA512_SUM0: begin
                    comp_result  = XLEN'(ror64(a64, 28) ^ ror64(a64, 34) ^ ror64(a64, 39));
                    comp_illegal = 1'b0;
                end
                SHA512_SUM1: begin
                    comp_result  = XLEN'(ror64(a64, 14) ^ ror64(a64, 18) ^ ror64(a64, 41));
                    comp_illegal = 1'b0;
                end
                default: ;
            endcase
        end else begin
            case (op_i)
                SHA512_SUM0R: begin
                    comp_result  = XLEN'((a32 << 25) ^ (a32 << 30) ^ (a32 >> 28) ^
                                         (b32 >> 7) ^ (b32 >> 2) ^ (b32 << 4));
                    comp_illegal = 1'b0;
                end
                SHA512_SUM1R: begin
                    comp_result  = XLEN'((a32 << 23) ^ (a32 >> 14) ^ (a32 >> 18) ^
                                         (b32 >> 9) ^ (b32 << 18) ^ (b32 << 14));
                    comp_illegal = 1'b0;
                end
                SHA512_SIG0H, SHA512_SIG0L: begin
                    comp_result  = XLEN'((a32 >> 1) ^ (a32 >> 7) ^ (a32 >> 8) ^
                                         (b32 << 31) ^ (b32 << 24) ^
                                         ((op_i == SHA512_SIG0L) ? (b32 << 25) : 32'd0));
                    comp_illegal = 1'b0;
                end
                SHA512_SIG1H, SHA512_SIG1L: begin
                    comp_result  = XLEN'((a32 << 3) ^ (a32 >> 6) ^ (a32 >> 19) ^
                                         (b32 >> 29) ^ (b32 << 13) ^
                                         ((op_i == SHA512_SIG1L) ? (b32 << 26) : 32'd0));
                    comp_illegal = 1'b0;
                end
                default: ;
            endcase
        end
    end

    if (PIPE_STAGES == 0) begin : g_comb
        // A flushed input is dropped: accepted but never presented downstream.
        assign valid_o    = valid_i && !flush_i;
        assign ready_o    = ready_i || flush_i;
        assign result_o   = comp_result;
        assign trans_id_o = trans_id_i;
        assign illegal_o  = comp_illegal;
    end else begin : g_pipe
        logic [PIPE_STAGES-1:0] stage_valid;
        logic [PIPE_STAGES-1:0] stage_rdy;
        payload_t               chain_data [PIPE_STAGES+1];
        logic [PIPE_STAGES:0]   chain_valid;

        assign chain_valid[0] = valid_i;
        assign chain_data[0]  = '{result: comp_result, trans_id: trans_id_i, illegal: comp_illegal};

        // A stage may load when it, or any stage after it, has a hole, or the sink drains.
        // NOTE: the running accumulator uses blocking assignments; it is combinational, not state.
        always_comb begin
            logic acc;
            acc       = ready_i;
            stage_rdy = '0;
            for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
                acc          = acc || !stage_valid[k];
                stage_rdy[k] = acc;
            end
        end

        for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
            logic     valid_q;
            payload_t data_q;

            // NOTE: sequential state is updated with non-blocking assignments only.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    if (flush_i) begin
                        valid_q <= 1'b0;
                    end else if (stage_rdy[k]) begin
                        valid_q <= chain_valid[k];
                    end
                    if (stage_rdy[k]) begin
                        data_q <= chain_data[k];
                    end
                end
            end

            assign stage_valid[k]    = valid_q;
            assign chain_valid[k+1]  = valid_q;
            assign chain_data[k+1]   = data_q;
        end

        assign ready_o    = stage_rdy[0];
        assign valid_o    = stage_valid[PIPE_STAGES-1];
        assign result_o   = chain_data[PIPE_STAGES].result;
        assign trans_id_o = chain_data[PIPE_STAGES].trans_id;
        assign illegal_o  = chain_data[PIPE_STAGES].illegal;
    end

endmodule
